// File: rtl/summ_pkg.sv
// rtl/summ_pkg.sv - shared mode encodings, FSM states and hex-to-segment decoding for summator_acc
package summ_pkg;

    localparam logic [1:0] MODE_ADD     = 2'b00;
    localparam logic [1:0] MODE_SUB     = 2'b01;
    localparam logic [1:0] MODE_ACC_ADD = 2'b10;
    localparam logic [1:0] MODE_ACC_SUB = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_EXEC,
        ST_SHOW
    } state_t;

    // Active-low gfedcba patterns, entry 15 (F) first
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - two-flop synchroniser, stability counter and one-cycle release pulse
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic release_evt
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == CW'(DEB_CYCLES - 1));

    // Idle pad level is high (released), so everything resets to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            level       <= 1'b1;
            cnt         <= '0;
            release_evt <= 1'b0;
        end else begin
            sync1       <= key;
            sync2       <= sync1;
            release_evt <= accept && sync2;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/summator_acc.sv
// rtl/summator_acc.sv - switch-driven add/sub/accumulate summator with hex displays; SUMM_ACC_SAT_EN enables accumulator saturation
module summator_acc
    import summ_pkg::*;
#(
    parameter  int W          = 8,
    parameter  int DEB_CYCLES = 16,
    localparam int OD         = (W + 3) / 4,
    localparam int RD         = (W + 4) / 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key0,
    input  logic            key1,
    input  logic [1:0]      mode,
    input  logic [2*W-1:0]  SW,
    output logic [7*OD-1:0] seg_a,
    output logic [7*OD-1:0] seg_b,
    output logic [7*RD-1:0] seg_r,
    output logic            LEDG,
    output logic            LEDR,
    output logic            busy
);

    localparam int OW = 4 * OD;
    localparam int RW = 4 * RD;

    logic         clr_evt;
    logic         exe_evt;
    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] a_disp;
    logic [W-1:0] b_disp;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   op_mode;
    logic [W-1:0] acc;
    logic [W:0]   res;

    logic         accm;
    logic         sub;
    logic [W-1:0] lhs;
    logic [W-1:0] rhs;
    logic [W:0]   raw;
    logic [W:0]   alu_res;
    logic         alu_ledg;
    logic         alu_ledr;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_key (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key0),
        .release_evt (clr_evt)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exe_key (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key1),
        .release_evt (exe_evt)
    );

    // Clear pre-empts everything, including a same-cycle execute
    always_comb begin
        state_nxt = state;
        if (clr_evt) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (exe_evt) state_nxt = ST_LATCH;
                ST_LATCH: state_nxt = ST_EXEC;
                ST_EXEC:  state_nxt = ST_SHOW;
                ST_SHOW:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    // Accumulate modes use acc as the first operand and A as the second
    always_comb begin
        accm     = (op_mode == MODE_ACC_ADD) || (op_mode == MODE_ACC_SUB);
        sub      = (op_mode == MODE_SUB) || (op_mode == MODE_ACC_SUB);
        lhs      = accm ? acc : op_a;
        rhs      = accm ? op_a : op_b;
        raw      = sub ? ({1'b0, lhs} - {1'b0, rhs}) : ({1'b0, lhs} + {1'b0, rhs});
        alu_ledg = raw[W];
        alu_ledr = ((lhs[W-1] ^ rhs[W-1]) == sub) && (raw[W-1] != lhs[W-1]);
        alu_res  = raw;
`ifdef SUMM_ACC_SAT_EN
        if (accm) begin
            alu_res[W] = 1'b0;
            if (raw[W]) alu_res[W-1:0] = sub ? '0 : '1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_disp  <= '0;
            b_disp  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_mode <= MODE_ADD;
            acc     <= '0;
            res     <= '0;
            LEDG    <= 1'b0;
            LEDR    <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_disp <= SW[2*W-1:W];
            b_disp <= SW[W-1:0];
            if (clr_evt) begin
                acc  <= '0;
                res  <= '0;
                LEDG <= 1'b0;
                LEDR <= 1'b0;
            end else if (state == ST_LATCH) begin
                op_a    <= SW[2*W-1:W];
                op_b    <= SW[W-1:0];
                op_mode <= mode;
            end else if (state == ST_EXEC) begin
                res  <= alu_res;
                LEDG <= alu_ledg;
                LEDR <= alu_ledr;
                if (accm) acc <= alu_res[W-1:0];
            end
        end
    end

    logic [OW-1:0] a_pad;
    logic [OW-1:0] b_pad;
    logic [RW-1:0] r_pad;

    assign a_pad = OW'(a_disp);
    assign b_pad = OW'(b_disp);
    assign r_pad = RW'(res);

    for (genvar k = 0; k < OD; k++) begin : g_op_digit
        assign seg_a[7*k +: 7] = hex_to_seg(a_pad[4*k +: 4]);
        assign seg_b[7*k +: 7] = hex_to_seg(b_pad[4*k +: 4]);
    end

    for (genvar k = 0; k < RD; k++) begin : g_res_digit
        assign seg_r[7*k +: 7] = hex_to_seg(r_pad[4*k +: 4]);
    end

endmodule

// File: tb/tb_summator_acc.sv
// tb/tb_summator_acc.sv - scoreboard bench for summator_acc (W=8, short debounce)
module tb_summator_acc;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        key0  = 1'b1;
    logic        key1  = 1'b1;
    logic [1:0]  mode  = 2'b00;
    logic [15:0] SW    = '0;
    logic [13:0] seg_a;
    logic [13:0] seg_b;
    logic [20:0] seg_r;
    logic        LEDG;
    logic        LEDR;
    logic        busy;

    summator_acc #(.W(W), .DEB_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .key0  (key0),
        .key1  (key1),
        .mode  (mode),
        .SW    (SW),
        .seg_a (seg_a),
        .seg_b (seg_b),
        .seg_r (seg_r),
        .LEDG  (LEDG),
        .LEDR  (LEDR),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] res;
        logic       ledg;
        logic       ledr;
        logic       chk_ledr;
        int         blen;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   ops         = 0;
    int   blen        = 0;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [20:0] seg_res(input logic [8:0] r);
        return {seg7({3'b000, r[8]}), seg7(r[7:4]), seg7(r[3:0])};
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endfunction

    // Monitor: a result is presented when busy drops
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (blen == 0) ops++;
            blen++;
        end else if (blen > 0) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got seg_r 0x%0h, want no operation", seg_r);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("seg_r", seg_r, seg_res(e.res));
                check("LEDG", LEDG, e.ledg);
                if (e.chk_ledr) check("LEDR", LEDR, e.ledr);
                check("busy_len", blen, e.blen);
            end
            blen = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_op(input logic [8:0] r, input logic g, input logic v, input logic ck, input int bl);
        exp_t e;
        e.res = r; e.ledg = g; e.ledr = v; e.chk_ledr = ck; e.blen = bl;
        sb.push_back(e);
    endtask

    task automatic exec_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                           input logic [8:0] r, input logic g, input logic v, input logic ck);
        mode = m;
        SW   = {a, b};
        expect_op(r, g, v, ck, 3);
        key1 = 1'b0; tick(DEB + 4);
        key1 = 1'b1; tick(DEB + 12);
    endtask

    task automatic clear_key();
        key0 = 1'b0; tick(DEB + 4);
        key0 = 1'b1; tick(DEB + 10);
    endtask

    initial begin
        int ops0;
        int t;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_LEDG", LEDG, 0);
        check("rst_LEDR", LEDR, 0);
        check("rst_seg_r", seg_r, seg_res(9'h000));
        rst_n = 1'b1;
        SW = 16'hA53C;
        tick(2);
        check("seg_a", seg_a, {seg7(4'hA), seg7(4'h5)});
        check("seg_b", seg_b, {seg7(4'h3), seg7(4'hC)});

        exec_op(2'b00, 8'h7F, 8'h01, 9'h080, 1'b0, 1'b1, 1'b1);
        exec_op(2'b01, 8'h05, 8'h09, 9'h1FC, 1'b1, 1'b0, 1'b1);
        exec_op(2'b10, 8'h90, 8'h00, 9'h090, 1'b0, 1'b0, 1'b1);
`ifdef SUMM_ACC_SAT_EN
        exec_op(2'b10, 8'h90, 8'h00, 9'h0FF, 1'b1, 1'b0, 1'b0);
`else
        exec_op(2'b10, 8'h90, 8'h00, 9'h120, 1'b1, 1'b1, 1'b1);
`endif

        // Bouncy release must yield exactly one operation
        mode = 2'b00;
        SW   = 16'h1234;
        expect_op(9'h046, 1'b0, 1'b0, 1'b1, 3);
        ops0 = ops;
        key1 = 1'b0; tick(DEB + 4);
        for (int i = 0; i < 5; i++) begin
            key1 = ~key1; tick(2);
        end
        tick(DEB + 12);
        check("bounce_ops", ops - ops0, 1);

        clear_key();
        check("clr_seg_r", seg_r, seg_res(9'h000));
        check("clr_LEDG", LEDG, 0);
        exec_op(2'b10, 8'h33, 8'h00, 9'h033, 1'b0, 1'b0, 1'b1);

        // Simultaneous clear and execute: clear wins, nothing executes
        ops0 = ops;
        key0 = 1'b0; key1 = 1'b0; tick(DEB + 4);
        key0 = 1'b1; key1 = 1'b1; tick(DEB + 12);
        check("clr_exe_ops", ops - ops0, 0);
        check("clr_exe_seg_r", seg_r, seg_res(9'h000));
        check("clr_exe_LEDG", LEDG, 0);
        check("clr_exe_LEDR", LEDR, 0);
        exec_op(2'b10, 8'h01, 8'h00, 9'h001, 1'b0, 1'b0, 1'b1);
`ifdef SUMM_ACC_SAT_EN
        exec_op(2'b11, 8'h02, 8'h00, 9'h000, 1'b1, 1'b0, 1'b0);
`else
        exec_op(2'b11, 8'h02, 8'h00, 9'h1FF, 1'b1, 1'b0, 1'b1);
`endif

        // Reset asserted during EXEC
        mode = 2'b00;
        SW   = 16'hFF01;
        expect_op(9'h000, 1'b0, 1'b0, 1'b1, 2);
        key1 = 1'b0; tick(DEB + 4);
        key1 = 1'b1;
        t = 0;
        while (busy !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("busy_rise_timeout", t < 50, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        tick(2);
        check("rst_exec_busy", busy, 0);
        check("rst_exec_seg_r", seg_r, seg_res(9'h000));
        check("rst_exec_LEDG", LEDG, 0);
        rst_n = 1'b1;
        tick(2);
        exec_op(2'b00, 8'hFF, 8'h01, 9'h100, 1'b1, 1'b0, 1'b1);

        check("scoreboard_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/summator_acc.md
Name: summator_acc

Overview:
- Parametrised successor of the two-operand board summator.
- Operands A and B come from slide switches. Debounced push-buttons trigger "execute" and "clear".
- Supports add, subtract and running-accumulate modes, with carry and overflow flags.
- Drives 7-segment hex digits for A, B and the result. Sits at board top level between the switch/key pads and the HEX/LED pads.

Parameters:
- W, 8, operand width in bits (4..16).
- DEB_CYCLES, 16, clock cycles a key level must stay stable before it is accepted (>=2).
- OD, derived localparam = ceil(W/4), hex digits per operand display.
- RD, derived localparam = ceil((W+1)/4), hex digits for the result display.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- key0  in  1  clear button, raw pad (pressed = 0).
- key1  in  1  execute button, raw pad (pressed = 0).
- mode  in  2  operation: 00 ADD, 01 SUB, 10 ACC_ADD, 11 ACC_SUB.
- SW  in  2*W  A = SW[2W-1:W], B = SW[W-1:0].
- seg_a  out  7*OD  A digits, digit k at [7k+6:7k], active-low segments.
- seg_b  out  7*OD  B digits, same format.
- seg_r  out  7*RD  result digits, same format.
- LEDG  out  1  carry (ADD/ACC_ADD) or borrow (SUB/ACC_SUB) of last operation.
- LEDR  out  1  signed two's-complement overflow of last operation.
- busy  out  1  high while the FSM is not IDLE.

Behaviour:
- Keys: two-flop synchroniser, then debounce counter. The counter resets on any level change and accepts the new level after DEB_CYCLES stable cycles. An event is a one-cycle pulse on the accepted 0->1 transition (button release).
- A and B displays follow SW combinationally through registered copies, with 1-cycle latency.
- Registers: res[W:0] (bit W = carry), acc[W-1:0], LEDG, LEDR. All reset to 0; FSM resets to IDLE. Asserting rst_n low aborts any operation immediately.
- FSM states: IDLE, LATCH, EXEC, SHOW.
  - IDLE: execute event -> LATCH.
  - LATCH: capture A, B and mode into operand registers -> EXEC. SW changes after this cycle are ignored.
  - EXEC: compute and update res/acc/flags -> SHOW.
  - SHOW: 1 cycle -> IDLE.
  - Result is valid 3 cycles after the execute pulse. busy is high in LATCH, EXEC and SHOW.
- Arithmetic, all mod 2^W with the carry in bit W:
  - ADD: res = A + B.
  - SUB: res = A - B; LEDG = borrow (A < B unsigned).
  - ACC_ADD: acc = acc + A; res = {carry, acc_new}.
  - ACC_SUB: acc = acc - A; res = {borrow, acc_new}.
  - ADD/SUB leave acc unchanged.
  - LEDR: operand sign bits equal (ADD) or different (SUB) and the result sign differs from the first operand.
- Clear event: res, acc, LEDG and LEDR go to 0 next cycle and the FSM returns to IDLE.
  - Clear wins over execute in the same cycle.
  - Clear during LATCH/EXEC abandons the operation with no update.
- Execute events arriving while busy are dropped (not queued).
- Wrap-around: acc wraps modulo 2^W; LEDG flags each wrap.
- Unused high bits of the top digit are zero-filled.
- Segment encoding is the standard 0-F active-low table: 0 = 1000000, F = 0001110.

Optional Feature:
- Macro SUMM_ACC_SAT_EN.
- Defined: ACC_ADD saturates acc at 2^W-1 and ACC_SUB at 0. LEDG is set when saturation occurred. res[W] = 0 in accumulate modes.
- Undefined: wrap as described above. ADD/SUB are unaffected either way.

Decomposition:
- Shared package summ_pkg holds:
  - mode encodings (MODE_ADD/SUB/ACC_ADD/ACC_SUB);
  - FSM state typedef;
  - the 16-entry segment constant table and a hex-to-segment function.
- One natural sub-module: key_debounce (sync + DEB_CYCLES counter + release pulse), instantiated for key0 and key1.
- Digit decoding is a generate loop using the package function.

Test Plan:
- W=8, mode=ADD, SW A=0x7F B=0x01, release key1 -> 3 cycles later seg_r shows 080, LEDG=0, LEDR=1, busy high exactly 3 cycles.
- mode=SUB, A=0x05 B=0x09, execute -> res low byte 0xFC, LEDG=1 (borrow), LEDR=0.
- mode=ACC_ADD, A=0x90, execute twice -> acc 0x90 then 0x20 with LEDG=1 on the second. With SUMM_ACC_SAT_EN: 0x90 then 0xFF, LEDG=1.
- key1 bounce of 5 toggles, each shorter than DEB_CYCLES, then stable release -> exactly one execute pulse.
- key0 and key1 released in the same cycle after acc=0x33 -> acc=0, res=0, no EXEC entered.
- rst_n pulled low while in EXEC -> all outputs 0 and FSM IDLE asynchronously; the next execute works normally.
